// File: rtl/data_mem_ctrl_if.sv
// Request/response bus of the MEM-stage data memory.
// The master drives requests; the slave returns a one-cycle registered response.
interface data_mem_ctrl_if #(
  parameter int BITS   = 64,
  parameter int ADDR_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [BITS-1:0]   req_wdata;
  logic              rsp_valid;
  logic [BITS-1:0]   rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// RISC-V data memory: byte-addressed little-endian BITS-wide words with byte-lane
// stores, sign/zero-extended loads, error checks and a post-reset clear sweep.
module data_mem_ctrl #(
  parameter int BITS   = 64,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_ctrl_if.slave bus,
  output logic           init_done
);

  localparam int NBYTES = BITS / 8;
  localparam int OFF_W  = $clog2(NBYTES);
  localparam int IDX_W  = $clog2(DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [BITS-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic [BITS-1:0]    mem [DEPTH];

  logic               mem_we;
  logic [IDX_W-1:0]   mem_widx;
  logic [BITS-1:0]    mem_wdata;

  logic               accept;
  logic [ADDR_W-1:0]  word_idx;
  logic [OFF_W-1:0]   byte_off;
  logic [3:0]         nbytes;
  logic [BITS-1:0]    size_mask;
  logic               misaligned;
  logic               req_err;
  logic [BITS-1:0]    rd_word;
  logic [BITS-1:0]    shifted;
  logic               sign_bit;
  logic [BITS-1:0]    load_val;
  logic [BITS-1:0]    wr_mask;
  logic [BITS-1:0]    wr_data;

  // Request decode: all masks are derived from the access size so that loads and
  // stores share one alignment/extension path.
  always_comb begin
    accept   = (state_q == ST_RUN) && bus.req_valid;
    word_idx = bus.req_addr >> OFF_W;
    byte_off = bus.req_addr[OFF_W-1:0];
    nbytes   = 4'd1 << bus.req_funct3[1:0];

    size_mask = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (4'(i) < nbytes) size_mask[i*8 +: 8] = 8'hFF;
    end

    misaligned = (OFF_W'(nbytes - 4'd1) & byte_off) != '0;
    req_err    = (bus.req_funct3 == 3'b111)
               || (bus.req_funct3[2] && bus.req_we)
               || ((BITS == 32) && ((bus.req_funct3 == 3'b110) || (bus.req_funct3[1:0] == 2'b11)))
               || misaligned
               || (word_idx >= ADDR_W'(DEPTH));

    rd_word  = mem[word_idx[IDX_W-1:0]];
    shifted  = rd_word >> {byte_off, 3'b000};
    sign_bit = |(shifted & size_mask & ~(size_mask >> 1));
    load_val = shifted & size_mask;
    if (!bus.req_funct3[2] && sign_bit) load_val = load_val | ~size_mask;

    wr_mask = size_mask << {byte_off, 3'b000};
    wr_data = (bus.req_wdata & size_mask) << {byte_off, 3'b000};
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    mem_we      = 1'b0;
    mem_widx    = ptr_q;
    mem_wdata   = '0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (accept) begin
          rsp_valid_d = 1'b1;
          if (req_err) begin
            rsp_err_d = 1'b1;
          end else if (bus.req_we) begin
            mem_we    = 1'b1;
            mem_widx  = word_idx[IDX_W-1:0];
            mem_wdata = (rd_word & ~wr_mask) | (wr_data & wr_mask);
          end else begin
            rsp_rdata_d = load_val;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array has no reset; the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  assign bus.req_ready = (state_q == ST_RUN);
  assign init_done     = (state_q == ST_RUN);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: byte-array reference model, directed
// plan cases plus randomized traffic, monitor pops expectations on rsp_valid.
module tb_data_mem_ctrl;

  localparam int BITS   = 64;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 8;

  typedef struct packed {
    logic        err;
    logic [63:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic init_done;

  data_mem_ctrl_if #(.BITS(BITS), .ADDR_W(ADDR_W)) bus ();

  data_mem_ctrl #(.BITS(BITS), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];
  logic [7:0] ref_mem [DEPTH*8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=0x%016h expected=0x%016h", name, got, want);
    end
  endtask

  // Reference model: memory as a flat byte array, responses from plain arithmetic.
  function automatic rsp_t model(input logic we, input logic [2:0] f3,
                                 input logic [7:0] addr, input logic [63:0] wd);
    rsp_t r;
    int nb;
    int off;
    nb     = 1 << f3[1:0];
    off    = int'(addr) % 8;
    r.err  = (f3 == 3'b111) || (f3[2] && we) || ((off % nb) != 0);
    r.data = '0;
    if (!r.err) begin
      if (we) begin
        for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) r.data[8*i +: 8] = ref_mem[int'(addr) + i];
        if (!f3[2] && nb < 8 && r.data[8*nb-1])
          r.data = r.data | ~((64'd1 << (8*nb)) - 64'd1);
      end
    end
    return r;
  endfunction

  // Issue one request; exp_mode=1 overrides the model's answer with a fixed value.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                        input logic [63:0] wd, input bit exp_mode = 1'b0,
                        input logic exp_err = 1'b0, input logic [63:0] exp_data = '0);
    rsp_t r;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    r = model(we, f3, addr, wd);
    if (exp_mode) begin
      r.err  = exp_err;
      r.data = exp_data;
    end
    exp_q.push_back(r);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    int cnt;
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < DEPTH*8; i++) ref_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
    check("rst_rsp_err",   64'(bus.rsp_err), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    rst_n = 1'b1;
    cnt = 0;
    while (!bus.req_ready && cnt < 100) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    check("init_ready_low_cycles", 64'(cnt), 64'd32);
    check("init_done_after_init", 64'(init_done), 64'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp got rsp_valid=1 expected no response");
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
          check("rsp_rdata", bus.rsp_rdata, e.data);
        end
      end else if (exp_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL missing_rsp got rsp_valid=0 expected a response");
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] f3;
    logic [7:0] a;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    do_reset();
    do_req(1'b0, 3'b011, 8'h10, '0, 1'b1, 1'b0, 64'd0);

    // Byte and half stores into a double word.
    do_req(1'b1, 3'b011, 8'h08, 64'h1122334455667788);
    do_req(1'b1, 3'b000, 8'h0B, 64'h00000000000000AA);
    do_req(1'b0, 3'b011, 8'h08, '0, 1'b1, 1'b0, 64'h11223344AA667788);
    do_req(1'b1, 3'b001, 8'h0C, 64'h000000000000BEEF);
    do_req(1'b0, 3'b011, 8'h08, '0, 1'b1, 1'b0, 64'h1122BEEFAA667788);

    // Sign and zero extension.
    do_req(1'b1, 3'b011, 8'h00, 64'hFFFFFFFF80000080);
    do_req(1'b0, 3'b000, 8'h00, '0, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFF80);
    do_req(1'b0, 3'b100, 8'h00, '0, 1'b1, 1'b0, 64'h0000000000000080);
    do_req(1'b0, 3'b010, 8'h00, '0, 1'b1, 1'b0, 64'hFFFFFFFF80000080);
    do_req(1'b0, 3'b110, 8'h00, '0, 1'b1, 1'b0, 64'h0000000080000080);

    // Error cases; memory must stay untouched.
    do_req(1'b0, 3'b010, 8'h06, '0, 1'b1, 1'b1, 64'd0);
    do_req(1'b1, 3'b001, 8'h03, 64'h000000000000FFFF, 1'b1, 1'b1, 64'd0);
    do_req(1'b0, 3'b011, 8'h00, '0, 1'b1, 1'b0, 64'hFFFFFFFF80000080);
    do_req(1'b0, 3'b111, 8'h00, '0, 1'b1, 1'b1, 64'd0);
    do_req(1'b1, 3'b100, 8'h00, 64'h55, 1'b1, 1'b1, 64'd0);
    do_req(1'b0, 3'b011, 8'h00, '0, 1'b1, 1'b0, 64'hFFFFFFFF80000080);
    idle(2);

    // Back-to-back store then load of the same address.
    do_req(1'b1, 3'b011, 8'h18, 64'h000000000000DEAD, 1'b1, 1'b0, 64'd0);
    do_req(1'b0, 3'b011, 8'h18, '0, 1'b1, 1'b0, 64'h000000000000DEAD);
    idle(2);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) a = a & ~(8'((1 << f3[1:0]) - 1));
      do_req(1'($urandom_range(0, 1)), f3, a, {$urandom, $urandom});
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    idle(2);

    // Reset lands while a load response is pending.
    do_req(1'b0, 3'b011, 8'h18, '0);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("midrst_req_ready", 64'(bus.req_ready), 64'd0);
    do_reset();
    do_req(1'b0, 3'b011, 8'h18, '0, 1'b1, 1'b0, 64'd0);
    do_req(1'b0, 3'b011, 8'h08, '0, 1'b1, 1'b0, 64'd0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised RISC-V data memory for the core's MEM stage: byte-addressed, little-endian, BITS-wide words, DEPTH words.
- Supports LB/LH/LW/LD, LBU/LHU/LWU and SB/SH/SW/SD, with sign/zero extension and byte-lane writes.
- Uses a valid/ready request port, a registered response port, error reporting, and a post-reset memory clear sequence.

Parameters:
- BITS, 64, word width in bits; legal values 32 or 64.
- DEPTH, 32, number of words; power of two, 2..1024.
- ADDR_W, 8, byte-address width; must be at least log2(DEPTH)+log2(BITS/8).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 size/sign code.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  BITS  store data; the low bytes are used.
- rsp_valid  out  1  single-cycle response pulse.
- rsp_rdata  out  BITS  load result, extended to BITS; 0 for stores and errors.
- rsp_err  out  1  request rejected; valid only while rsp_valid=1.
- init_done  out  1  memory clear finished.

Behaviour:
- Reset, while rst_n=0: state=INIT, clear pointer=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
- INIT state:
  - Each cycle writes 0 to word[ptr] and increments ptr.
  - After the edge that writes word DEPTH-1, state becomes RUN and init_done=1.
  - Takes exactly DEPTH cycles after rst_n rises. req_ready stays 0 and requests are ignored.
- RUN state:
  - req_ready=1 every cycle; there is no response backpressure.
  - A request is accepted when req_valid && req_ready at a rising edge. Back-to-back acceptance every cycle is allowed.
- Latency: the response for a request accepted at edge N is presented after edge N, with rsp_valid=1 for exactly one cycle. rsp_valid=0 in cycles with no accept.
- Word index = req_addr >> log2(BITS/8). Byte offset = the low log2(BITS/8) address bits.
- Size by funct3[1:0]: 00 = byte, 01 = half, 10 = word, 11 = double. funct3[2]=1 means zero-extend.
- Error conditions. Any one of these sets rsp_err=1, rsp_rdata=0, and leaves memory unmodified:
  - funct3 = 111;
  - funct3[2]=1 with req_we=1;
  - funct3 = 110 (LWU) when BITS=32;
  - double access (funct3 = 011) when BITS=32;
  - byte offset not a multiple of the access size (misaligned);
  - word index >= DEPTH (only reachable if ADDR_W exceeds the minimum).
- Store:
  - Writes only the addressed byte lanes, at the same edge as the accept.
  - The lowest size bytes of req_wdata go to lanes starting at the byte offset; the other lanes are unchanged.
  - Response: rsp_rdata=0, rsp_err=0.
- Load:
  - Word read at the accept edge. Selected bytes are shifted to bit 0 and sign- or zero-extended to BITS.
  - Registered into rsp_rdata.
- Store followed by a load to the same address on the next cycle: the load returns the new data. No forwarding logic is needed; the store completes at the earlier edge.
- Reset asserted mid-operation or mid-INIT:
  - Pending response is dropped; outputs return to reset values immediately (asynchronously).
  - INIT restarts from word 0 when rst_n rises.
- Memory array contents are not reset asynchronously; only the INIT sequence clears them.

Test Plan:
- Reset/init: rst_n low for 3 cycles, then high. Required: req_ready=0 for exactly 32 cycles, then init_done=1 and req_ready=1. A load of addr 0x10 with funct3 011 returns 0.
- Byte/half stores:
  - SD 0x1122334455667788 to addr 0x08, then SB 0xAA to addr 0x0B. LD 0x08 returns 0x11223344AA667788.
  - SH 0xBEEF to addr 0x0C. LD 0x08 returns 0x1122BEEFAA667788.
- Sign extension after the SD of 0xFFFFFFFF80000080 to 0x00:
  - LB 0x00 returns 0xFFFFFFFFFFFFFF80.
  - LBU 0x00 returns 0x0000000000000080.
  - LW 0x00 returns 0xFFFFFFFF80000080.
  - LWU 0x00 returns 0x0000000080000080.
- Errors:
  - LW at 0x06 (misaligned) -> rsp_err=1, rsp_rdata=0.
  - SH at 0x03 -> rsp_err=1 and memory unchanged.
  - funct3 111 -> rsp_err=1.
  - SBU-style (funct3 100, we=1) -> rsp_err=1.
- Back-to-back: SD 0xDEAD to 0x18 at edge N, LD 0x18 at edge N+1. Required: rsp_valid high in both following cycles; the second response is 0x000000000000DEAD.
- Mid-operation reset: accept an LD, then drop rst_n before the next edge. Required: rsp_valid falls to 0 immediately. After release, req_ready stays 0 for 32 cycles.
